// File: rtl/load_store_unit_pkg.sv
// Shared types and constants for the load/store unit: FSM states, RV32I
// load/store funct3 encodings, access sizes and byte-enable patterns.
package load_store_unit_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } lsu_state_e;

    typedef enum logic [1:0] {
        BYTE = 2'd0,
        HALF = 2'd1,
        WORD = 2'd2
    } lsu_size_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    localparam logic [3:0] BE_NONE = 4'b0000;
    localparam logic [3:0] BE_B0   = 4'b0001;
    localparam logic [3:0] BE_LO   = 4'b0011;
    localparam logic [3:0] BE_HI   = 4'b1100;
    localparam logic [3:0] BE_ALL  = 4'b1111;

    function automatic lsu_size_e size_of(input logic [2:0] funct3);
        case (funct3[1:0])
            2'b00:   return BYTE;
            2'b01:   return HALF;
            default: return WORD;
        endcase
    endfunction

    // Legal encoding for the direction and naturally aligned for its size.
    function automatic logic access_ok(input logic is_load, input logic [2:0] funct3,
                                       input logic [1:0] offset);
        logic enc_ok;
        logic align_ok;
        if (is_load)
            enc_ok = (funct3 == F3_LB) || (funct3 == F3_LH) || (funct3 == F3_LW) ||
                     (funct3 == F3_LBU) || (funct3 == F3_LHU);
        else
            enc_ok = (funct3 == F3_SB) || (funct3 == F3_SH) || (funct3 == F3_SW);
        case (size_of(funct3))
            BYTE:    align_ok = 1'b1;
            HALF:    align_ok = ~offset[0];
            default: align_ok = (offset == 2'b00);
        endcase
        return enc_ok & align_ok;
    endfunction

endpackage

// File: rtl/load_store_unit_align.sv
// Picks the addressed byte/halfword out of a read word and sign- or
// zero-extends it according to the load funct3.
module load_align
    import load_store_unit_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr,
    input  logic [2:0]  funct3,
    output logic [31:0] result
);

    logic [31:0] byte_sel;
    logic [31:0] half_sel;
    logic        is_unsigned;

    assign byte_sel    = rdata >> {addr, 3'b000};
    assign half_sel    = rdata >> {addr[1], 4'b0000};
    assign is_unsigned = funct3[2];

    always_comb begin
        result = rdata;
        case (size_of(funct3))
            BYTE:    result = {{24{byte_sel[7] & ~is_unsigned}}, byte_sel[7:0]};
            HALF:    result = {{16{half_sel[15] & ~is_unsigned}}, half_sel[15:0]};
            default: result = rdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Memory-access stage: turns load/store instructions into a req/gnt/rvalid
// transaction, with lane steering, extension, alignment and timeout faults.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  reqValid,
    input  logic                  memRead,
    input  logic                  memWrite,
    input  logic [2:0]            funct3,
    input  logic [ADDR_WIDTH-1:0] aluResult,
    input  logic [31:0]           storeData,
    output logic                  reqReady,
    output logic                  stall,
    output logic                  memReq,
    output logic                  memWe,
    output logic [ADDR_WIDTH-1:0] memAddr,
    output logic [3:0]            memBe,
    output logic [31:0]           memWdata,
    input  logic                  memGnt,
    input  logic                  memRvalid,
    input  logic [31:0]           memRdata,
    output logic                  respValid,
    output logic [31:0]           loadData,
    output logic                  misaligned,
    output logic                  busError
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    lsu_state_e            state_reg, state_next;
    logic [ADDR_WIDTH-1:0] addr_reg;
    logic [3:0]            be_reg, be_next;
    logic [31:0]           wdata_reg, wdata_next;
    logic                  we_reg;
    logic [2:0]            f3_reg;
    logic [1:0]            off_reg;
    logic [CNT_W-1:0]      cnt_reg;
    logic [31:0]           load_data_reg;
    logic                  misaligned_reg;
    logic                  bus_error_reg;
    logic [31:0]           aligned_data;

    logic accept;
    logic legal;
    logic timeout_hit;
    logic rdata_take;

    // Both memRead and memWrite high is still taken, but answered as a fault.
    assign accept      = (state_reg == IDLE) & reqValid & (memRead | memWrite);
    assign legal       = (memRead ^ memWrite) & access_ok(memRead, funct3, aluResult[1:0]);
    assign timeout_hit = ((state_reg == REQ) || (state_reg == WAIT)) &&
                         (cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1));
    assign rdata_take  = (state_reg == WAIT) & memRvalid & ~timeout_hit;

    load_align u_align (
        .rdata  (memRdata),
        .addr   (off_reg),
        .funct3 (f3_reg),
        .result (aligned_data)
    );

    always_comb begin
        be_next    = BE_ALL;
        wdata_next = storeData;
        if (memWrite) begin
            case (size_of(funct3))
                BYTE: begin
                    be_next    = BE_B0 << aluResult[1:0];
                    wdata_next = {4{storeData[7:0]}};
                end
                HALF: begin
                    be_next    = aluResult[1] ? BE_HI : BE_LO;
                    wdata_next = {2{storeData[15:0]}};
                end
                default: begin
                    be_next    = BE_ALL;
                    wdata_next = storeData;
                end
            endcase
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (accept) state_next = legal ? REQ : DONE;
            REQ: begin
                if (timeout_hit)  state_next = DONE;
                else if (memGnt)  state_next = we_reg ? DONE : WAIT;
            end
            WAIT: begin
                if (timeout_hit || memRvalid) state_next = DONE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            addr_reg       <= '0;
            be_reg         <= BE_NONE;
            wdata_reg      <= '0;
            we_reg         <= 1'b0;
            f3_reg         <= '0;
            off_reg        <= '0;
            cnt_reg        <= '0;
            load_data_reg  <= '0;
            misaligned_reg <= 1'b0;
            bus_error_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                misaligned_reg <= ~legal;
                bus_error_reg  <= 1'b0;
                cnt_reg        <= '0;
                if (legal) begin
                    addr_reg  <= {aluResult[ADDR_WIDTH-1:2], 2'b00};
                    be_reg    <= be_next;
                    wdata_reg <= wdata_next;
                    we_reg    <= memWrite;
                    f3_reg    <= funct3;
                    off_reg   <= aluResult[1:0];
                end
            end else if ((state_reg == REQ) || (state_reg == WAIT)) begin
                cnt_reg <= cnt_reg + CNT_W'(1);
            end
            if (timeout_hit) begin
                bus_error_reg <= 1'b1;
                if (!we_reg) load_data_reg <= '0;
            end
            if (rdata_take) load_data_reg <= aligned_data;
        end
    end

    assign reqReady   = (state_reg == IDLE);
    assign memReq     = (state_reg == REQ);
    assign memWe      = we_reg;
    assign memAddr    = addr_reg;
    assign memBe      = be_reg;
    assign memWdata   = wdata_reg;
    assign respValid  = (state_reg == DONE);
    assign loadData   = load_data_reg;
    assign misaligned = misaligned_reg;
    assign busError   = bus_error_reg;
    assign stall      = reqValid & (memRead | memWrite) & ~respValid;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: aligned loads/stores, extension,
// delayed grant, fault paths, timeout and asynchronous reset mid-access.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        reqValid, memRead, memWrite;
    logic [2:0]  funct3;
    logic [31:0] aluResult, storeData;
    logic        reqReady, stall, memReq, memWe;
    logic [31:0] memAddr;
    logic [3:0]  memBe;
    logic [31:0] memWdata;
    logic        memGnt, memRvalid;
    logic [31:0] memRdata;
    logic        respValid;
    logic [31:0] loadData;
    logic        misaligned, busError;

    int n_cmp = 0;
    int n_err = 0;

    load_store_unit #(.ADDR_WIDTH(32), .TIMEOUT_CYCLES(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .reqValid   (reqValid),
        .memRead    (memRead),
        .memWrite   (memWrite),
        .funct3     (funct3),
        .aluResult  (aluResult),
        .storeData  (storeData),
        .reqReady   (reqReady),
        .stall      (stall),
        .memReq     (memReq),
        .memWe      (memWe),
        .memAddr    (memAddr),
        .memBe      (memBe),
        .memWdata   (memWdata),
        .memGnt     (memGnt),
        .memRvalid  (memRvalid),
        .memRdata   (memRdata),
        .respValid  (respValid),
        .loadData   (loadData),
        .misaligned (misaligned),
        .busError   (busError)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h, expected %08h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] sd);
        reqValid  = 1'b1;
        memRead   = rd;
        memWrite  = wr;
        funct3    = f3;
        aluResult = addr;
        storeData = sd;
    endtask

    task automatic release_req;
        reqValid = 1'b0;
        memRead  = 1'b0;
        memWrite = 1'b0;
    endtask

    // Load with grant in the first REQ cycle and rvalid the cycle after.
    task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] rdata, input logic [31:0] exp);
        drive(1'b1, 1'b0, f3, addr, 32'h0);
        check({tag, "_ready"}, {31'b0, reqReady}, 32'd1);
        tick;
        check({tag, "_req"}, {31'b0, memReq}, 32'd1);
        check({tag, "_addr"}, memAddr, {addr[31:2], 2'b00});
        check({tag, "_be"}, {28'b0, memBe}, 32'hF);
        check({tag, "_stall_req"}, {31'b0, stall}, 32'd1);
        memGnt = 1'b1;
        tick;
        memGnt    = 1'b0;
        memRvalid = 1'b1;
        memRdata  = rdata;
        check({tag, "_wait_noreq"}, {31'b0, memReq}, 32'd0);
        check({tag, "_stall_wait"}, {31'b0, stall}, 32'd1);
        tick;
        memRvalid = 1'b0;
        check({tag, "_resp"}, {31'b0, respValid}, 32'd1);
        check({tag, "_data"}, loadData, exp);
        check({tag, "_flags"}, {30'b0, misaligned, busError}, 32'd0);
        check({tag, "_stall_done"}, {31'b0, stall}, 32'd0);
        release_req;
        tick;
        check({tag, "_idle"}, {30'b0, respValid, reqReady}, 32'd1);
        $display("load %s addr=%08h data=%08h", tag, addr, loadData);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        release_req;
        funct3 = 3'b0; aluResult = '0; storeData = '0;
        memGnt = 1'b0; memRvalid = 1'b0; memRdata = '0;
        #12;
        check("rst_ready", {31'b0, reqReady}, 32'd1);
        check("rst_outs", {29'b0, memReq, respValid, memWe}, 32'd0);
        check("rst_load", loadData, 32'd0);
        rst_n = 1'b1;
        tick;

        do_load("lw", 3'b010, 32'h100, 32'hDEADBEEF, 32'hDEADBEEF);
        do_load("lb", 3'b000, 32'h103, 32'h80FF1234, 32'hFFFFFF80);
        do_load("lbu", 3'b100, 32'h103, 32'h80FF1234, 32'h00000080);

        // SH with grant held off for three REQ cycles
        drive(1'b0, 1'b1, 3'b001, 32'h202, 32'h0000ABCD);
        tick;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) memGnt = 1'b1;
            check("sh_req", {31'b0, memReq}, 32'd1);
            check("sh_addr", memAddr, 32'h200);
            check("sh_be", {28'b0, memBe}, 32'hC);
            check("sh_wdata", memWdata, 32'hABCDABCD);
            check("sh_we", {31'b0, memWe}, 32'd1);
            tick;
        end
        memGnt = 1'b0;
        check("sh_resp", {31'b0, respValid}, 32'd1);
        check("sh_noreq", {31'b0, memReq}, 32'd0);
        check("sh_loaddata_held", loadData, 32'h00000080);
        release_req;
        tick;
        $display("store sh addr=202 be=%h wdata=%08h", memBe, memWdata);

        // Misaligned word and illegal funct3: one-cycle fault, no request
        drive(1'b1, 1'b0, 3'b010, 32'h101, 32'h0);
        tick;
        check("mis_lw_resp", {31'b0, respValid}, 32'd1);
        check("mis_lw_flag", {31'b0, misaligned}, 32'd1);
        check("mis_lw_noreq", {31'b0, memReq}, 32'd0);
        release_req;
        tick;
        check("mis_lw_idle", {31'b0, respValid}, 32'd0);
        $display("fault lw addr=101 misaligned=%0b", misaligned);

        drive(1'b1, 1'b0, 3'b011, 32'h100, 32'h0);
        tick;
        check("ill_f3_resp", {31'b0, respValid}, 32'd1);
        check("ill_f3_flag", {31'b0, misaligned}, 32'd1);
        check("ill_f3_noreq", {31'b0, memReq}, 32'd0);
        release_req;
        tick;
        $display("fault funct3=011 misaligned=%0b", misaligned);

        // Load with grant never given: 16 cycles in REQ, then busError
        drive(1'b1, 1'b0, 3'b010, 32'h300, 32'h0);
        tick;
        check("to_misaligned_clr", {31'b0, misaligned}, 32'd0);
        for (int i = 0; i < 16; i++) begin
            check("to_req_held", {30'b0, memReq, respValid}, 32'd2);
            tick;
        end
        check("to_resp", {31'b0, respValid}, 32'd1);
        check("to_buserr", {31'b0, busError}, 32'd1);
        check("to_loaddata", loadData, 32'd0);
        check("to_noreq", {31'b0, memReq}, 32'd0);
        release_req;
        tick;
        $display("timeout load addr=300 busError=%0b", busError);

        do_load("lhu", 3'b101, 32'h106, 32'h80017FFF, 32'h00008001);
        do_load("lh", 3'b001, 32'h102, 32'h80017FFF, 32'hFFFF8001);

        // Asynchronous reset while waiting for read data
        drive(1'b1, 1'b0, 3'b010, 32'h400, 32'h12345678);
        tick;
        memGnt = 1'b1;
        tick;
        memGnt = 1'b0;
        check("rw_in_wait", {30'b0, memReq, reqReady}, 32'd0);
        #2 rst_n = 1'b0;
        #1;
        check("rw_addr", memAddr, 32'd0);
        check("rw_wdata", memWdata, 32'd0);
        check("rw_be", {28'b0, memBe}, 32'd0);
        check("rw_loaddata", loadData, 32'd0);
        check("rw_ctrl", {27'b0, memReq, memWe, respValid, misaligned, busError}, 32'd0);
        check("rw_idle", {31'b0, reqReady}, 32'd1);
        release_req;
        #2 rst_n = 1'b1;
        memRvalid = 1'b1;
        memRdata  = 32'hCAFEF00D;
        for (int i = 0; i < 3; i++) begin
            tick;
            check("rw_post_noresp", {30'b0, respValid, reqReady}, 32'd1);
            check("rw_post_loaddata", loadData, 32'd0);
        end
        memRvalid = 1'b0;
        $display("reset during wait: respValid=%0b loadData=%08h", respValid, loadData);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
